// File: rtl/uart_tx_cfg.sv
// Parametrised UART transmitter: start bit, 5..9 data bits (LSB first), optional parity, 1-2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input and the line-break state.
module uart_tx_cfg #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int P            = (PARITY != 0) ? 1 : 0;
  localparam int F            = 1 + DATA_BITS + P + STOP_BITS;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD       = (PARITY == 1);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_cfg: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
`ifdef UART_TX_BREAK_EN
    , BRK
`endif
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [IDX_W-1:0]     idx_reg, idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 par_reg, par_next;
  logic                 tx_reg, tx_next;
  logic                 busy_reg, busy_next;
  logic                 ready_reg, ready_next;
  logic                 done_reg, done_next;
  logic                 bit_end;

`ifdef UART_TX_BREAK_EN
  localparam int BRK_W = $clog2(F * CLKS_PER_BIT);
  localparam logic [BRK_W-1:0] BRK_LAST = BRK_W'(F * CLKS_PER_BIT - 1);

  logic [BRK_W-1:0] brk_cnt_reg, brk_cnt_next;
  logic             mark_reg, mark_next;
`endif

  assign bit_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = bit_end ? '0 : cnt_reg + 1'b1;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    ready_next = ready_reg;
    done_next  = 1'b0;
`ifdef UART_TX_BREAK_EN
    brk_cnt_next = brk_cnt_reg;
    mark_next    = mark_reg;
`endif

    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        idx_next   = '0;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
        ready_next = 1'b1;
`ifdef UART_TX_BREAK_EN
        if (brk && ready_reg) begin
          state_next   = BRK;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
          ready_next   = 1'b0;
          brk_cnt_next = '0;
          mark_next    = 1'b0;
        end else
`endif
        if (tx_valid && ready_reg) begin
          state_next = START;
          shift_next = tx_data;
          par_next   = (^tx_data) ^ PAR_ODD;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
          ready_next = 1'b0;
        end
      end

      START: begin
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
          shift_next = shift_reg >> 1;
          idx_next   = IDX_W'(1);
        end
      end

      // idx_reg counts data bits already put on the line
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IDX_DATA_LAST) begin
            idx_next = '0;
            if (P != 0) begin
              state_next = PAR;
              tx_next    = par_reg;
            end else begin
              state_next = STOP;
              tx_next    = 1'b1;
            end
          end else begin
            tx_next    = shift_reg[0];
            shift_next = shift_reg >> 1;
            idx_next   = idx_reg + 1'b1;
          end
        end
      end

      PAR: begin
        if (bit_end) begin
          state_next = STOP;
          tx_next    = 1'b1;
          idx_next   = '0;
        end
      end

      STOP: begin
        if (bit_end) begin
          if (idx_reg == IDX_STOP_LAST) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            ready_next = 1'b1;
            done_next  = 1'b1;
            idx_next   = '0;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      // Hold the line low for at least one frame time, then one mark bit.
      BRK: begin
        if (mark_reg) begin
          if (bit_end) begin
            state_next = IDLE;
            busy_next  = 1'b0;
            ready_next = 1'b1;
            mark_next  = 1'b0;
          end
        end else begin
          cnt_next = '0;
          if (brk_cnt_reg != BRK_LAST) begin
            brk_cnt_next = brk_cnt_reg + 1'b1;
          end else if (!brk) begin
            tx_next   = 1'b1;
            mark_next = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk_cnt_reg <= '0;
      mark_reg    <= 1'b0;
    end else begin
      brk_cnt_reg <= brk_cnt_next;
      mark_reg    <= mark_next;
    end
  end
`endif

  assign tx       = tx_reg;
  assign tx_busy  = busy_reg;
  assign tx_ready = ready_reg;
  assign tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg: 8N1, 7E2 and 7O2 instances at 10 clocks per bit.
// Break scenario is included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_cfg;

  logic       clk;
  logic       rst_n;
  logic [7:0] data8;
  logic [6:0] data7e;
  logic [6:0] data7o;
  logic [2:0] valid_s;
  logic [2:0] tx_s;
  logic [2:0] busy_s;
  logic [2:0] done_s;
  logic [2:0] ready_s;
`ifdef UART_TX_BREAK_EN
  logic       brk;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data8), .tx_valid(valid_s[0]),
`ifdef UART_TX_BREAK_EN
    .brk(brk),
`endif
    .tx_ready(ready_s[0]), .tx(tx_s[0]), .tx_busy(busy_s[0]), .tx_done(done_s[0])
  );

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_7e2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data7e), .tx_valid(valid_s[1]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_ready(ready_s[1]), .tx(tx_s[1]), .tx_busy(busy_s[1]), .tx_done(done_s[1])
  );

  uart_tx_cfg #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data7o), .tx_valid(valid_s[2]),
`ifdef UART_TX_BREAK_EN
    .brk(1'b0),
`endif
    .tx_ready(ready_s[2]), .tx(tx_s[2]), .tx_busy(busy_s[2]), .tx_done(done_s[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_data(input int u, input logic [7:0] v);
    case (u)
      0: data8  = v;
      1: data7e = v[6:0];
      default: data7o = v[6:0];
    endcase
  endtask

  // Caller raises valid at a negedge; accept happens at the following posedge.
  // exp holds the frame bits in line order, one character per bit time.
  task automatic send_and_check_frame(input int u, input string exp, input string name,
                                      input bit keep, input logic [7:0] next_data);
    logic [3:0] obs;
    logic [3:0] expv;
    for (int k = 0; k < exp.len() * 10; k++) begin
      @(negedge clk);
      if (k == 0) begin
        set_data(u, next_data);
        valid_s[u] = keep;
      end
      obs  = {tx_s[u], busy_s[u], done_s[u], ready_s[u]};
      expv = {(exp[k / 10] == "1"), 1'b1, 1'b0, 1'b0};
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL %s cycle %0d {tx,busy,done,ready} got %b expected %b", name, k, obs, expv);
      end
    end
    @(negedge clk);
    obs = {tx_s[u], busy_s[u], done_s[u], ready_s[u]};
    n_checks++;
    if (obs !== 4'b1011) begin
      n_fail++;
      $display("FAIL %s end_of_frame {tx,busy,done,ready} got %b expected 1011", name, obs);
    end
    if (!keep) begin
      @(negedge clk);
      obs = {tx_s[u], busy_s[u], done_s[u], ready_s[u]};
      n_checks++;
      if (obs !== 4'b1001) begin
        n_fail++;
        $display("FAIL %s after_done {tx,busy,done,ready} got %b expected 1001", name, obs);
      end
    end
    $display("frame %s unit %0d checked (%0d bits)", name, u, exp.len());
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    #12 rst_n = 1'b0;
    #1;
    for (int u = 0; u < 3; u++) begin
      obs = {tx_s[u], busy_s[u], done_s[u], ready_s[u]};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_values unit %0d {tx,busy,done,ready} got %b expected 1000", u, obs);
      end
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ready_s !== 3'b000) begin
      n_fail++;
      $display("FAIL ready_before_edge got %b expected 000", ready_s);
    end
    @(negedge clk);
    n_checks++;
    if ({ready_s, tx_s} !== 6'b111_111) begin
      n_fail++;
      $display("FAIL ready_after_release {ready,tx} got %b expected 111111", {ready_s, tx_s});
    end
    $display("reset test done");
  endtask

  task automatic test_8n1();
    data8 = 8'hA5;
    valid_s[0] = 1'b1;
    send_and_check_frame(0, "0101001011", "8n1_a5", 1'b0, 8'h00);
  endtask

  task automatic test_parity();
    data7e = 7'h55;
    valid_s[1] = 1'b1;
    send_and_check_frame(1, "01010101011", "7e2_55", 1'b0, 8'h00);
    data7o = 7'h55;
    valid_s[2] = 1'b1;
    send_and_check_frame(2, "01010101111", "7o2_55", 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    data8 = 8'h01;
    valid_s[0] = 1'b1;
    send_and_check_frame(0, "0100000001", "b2b_first_01", 1'b1, 8'h80);
    send_and_check_frame(0, "0000000011", "b2b_second_80", 1'b0, 8'hFF);
  endtask

  task automatic test_reset_mid_frame();
    logic [3:0] obs;
    data8 = 8'h00;
    valid_s[0] = 1'b1;
    @(negedge clk);
    valid_s[0] = 1'b0;
    repeat (45) @(negedge clk);
    obs = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
    n_checks++;
    if (obs !== 4'b0100) begin
      n_fail++;
      $display("FAIL midframe_before_reset {tx,busy,done,ready} got %b expected 0100", obs);
    end
    #2 rst_n = 1'b0;
    #1;
    obs = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
    n_checks++;
    if (obs !== 4'b1000) begin
      n_fail++;
      $display("FAIL midframe_reset_immediate {tx,busy,done,ready} got %b expected 1000", obs);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      obs = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
      n_checks++;
      if (obs !== 4'b1000) begin
        n_fail++;
        $display("FAIL midframe_reset_hold cycle %0d {tx,busy,done,ready} got %b expected 1000", k, obs);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    obs = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
    n_checks++;
    if (obs !== 4'b1001) begin
      n_fail++;
      $display("FAIL midframe_after_release {tx,busy,done,ready} got %b expected 1001", obs);
    end
    data8 = 8'h3C;
    valid_s[0] = 1'b1;
    send_and_check_frame(0, "0001111001", "after_reset_3c", 1'b0, 8'h00);
  endtask

`ifdef UART_TX_BREAK_EN
  task automatic test_break();
    logic [3:0] obs;
    logic [3:0] expv;
    brk = 1'b1;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (k == 49) brk = 1'b0;
      obs  = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
      expv = (k < 100) ? 4'b0100 : 4'b1100;
      n_checks++;
      if (obs !== expv) begin
        n_fail++;
        $display("FAIL break cycle %0d {tx,busy,done,ready} got %b expected %b", k, obs, expv);
      end
    end
    @(negedge clk);
    obs = {tx_s[0], busy_s[0], done_s[0], ready_s[0]};
    n_checks++;
    if (obs !== 4'b1001) begin
      n_fail++;
      $display("FAIL break_end {tx,busy,done,ready} got %b expected 1001", obs);
    end
    $display("break test done");
  endtask
`endif

  initial begin
    rst_n   = 1'b1;
    data8   = 8'h00;
    data7e  = 7'h00;
    data7o  = 7'h00;
    valid_s = 3'b000;
`ifdef UART_TX_BREAK_EN
    brk     = 1'b0;
`endif
    test_reset();
    test_8n1();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef UART_TX_BREAK_EN
    test_break();
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
